multicycle_control_hs: RTL and testbench

//  Main FSM for the multicycle RV32I core, with handshaked memory: every memory access waits on mem_ready.

---
 rtl/ctrl_pkg.sv | 90 +++++++++
 rtl/bus_watchdog.sv | 37 +++
 rtl/multicycle_control_hs.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_control_hs.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit:
// FSM states, datapath select codes, opcodes and trap causes.
package ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WRITE,
        S_MEM_WB,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_AUIPC,
        S_EXEC_LUI,
        S_PC_JALR,
        S_PC_JAL,
        S_PC_BRANCH,
        S_RD_CALC,
        S_COMPARE,
        S_REG_WRITE,
        S_MD_START,
        S_MD_WAIT,
        S_MD_WB,
        S_TRAP
    } state_e;

    localparam logic [1:0] A1_RS1   = 2'b00;
    localparam logic [1:0] A1_ZERO  = 2'b01;
    localparam logic [1:0] A1_OLDPC = 2'b10;
    localparam logic [1:0] A1_PC    = 2'b11;

    localparam logic [1:0] A2_IMM   = 2'b00;
    localparam logic [1:0] A2_RS2   = 2'b01;
    localparam logic [1:0] A2_FOUR  = 2'b10;

    localparam logic [1:0] RS_ALUOUT = 2'b00;
    localparam logic [1:0] RS_ALURES = 2'b01;
    localparam logic [1:0] RS_DATA   = 2'b10;
    localparam logic [1:0] RS_MD     = 2'b11;

    localparam logic [1:0] OP_FUNCT  = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_ADD    = 2'b10;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       instr_read;
        logic       mem_we;
        logic       pc_en;
        logic       fetch_en;
        logic       rf_en;
        logic       aluout_en;
        logic       data_en;
        logic       reg_we;
        logic       md_start;
        logic [1:0] alu_in1_src;
        logic [1:0] alu_in2_src;
        logic [1:0] result_src;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        mem_req: 1'b0, instr_read: 1'b0, mem_we: 1'b0, pc_en: 1'b0,
        fetch_en: 1'b0, rf_en: 1'b0, aluout_en: 1'b0, data_en: 1'b0,
        reg_we: 1'b0, md_start: 1'b0, alu_in1_src: A1_RS1,
        alu_in2_src: A2_IMM, result_src: RS_ALUOUT, alu_op: OP_FUNCT
    };

    // States that hold a memory request open until mem_ready.
    function automatic logic is_mem_wait(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Counts consecutive stalled cycles of an open memory request and flags a
// timeout on the last allowed cycle; TIMEOUT=0 disables it.
module bus_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic active,
    input  logic mem_ready,
    output logic trip
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        trip  = (TIMEOUT != 0) && en && active && !mem_ready && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (!active) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (mem_ready || trip) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control_hs.sv
// Main control FSM of the multicycle RV32I core with handshaked memory,
// bus watchdog, illegal-opcode trap and optional mul/div sequencing.
module multicycle_control_hs
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter bit MULDIV_EN = 1'b0,
    parameter bit TRAP_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       branch,
    input  logic [6:0] opCode,
    input  logic [6:0] funct7,
    input  logic       mem_ready,
    input  logic       md_done,
    output logic       mem_req,
    output logic       instr_read,
    output logic       mem_we,
    output logic       pc_en,
    output logic       fetch_en,
    output logic       rf_en,
    output logic       aluout_en,
    output logic       data_en,
    output logic       reg_we,
    output logic       md_start,
    output logic [1:0] alu_in1_src,
    output logic [1:0] alu_in2_src,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [1:0] trap_cause,
    output logic       halted
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       bus_err_q, bus_err_d;
    logic [1:0] cause_q, cause_d;
    ctrl_t      ctrl;
    logic       wd_trip;
    logic       adv;

    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .active    (is_mem_wait(state_q)),
        .mem_ready (mem_ready),
        .trip      (wd_trip)
    );

    always_comb begin
        // NOTE: every variable gets its default before the case so no path leaves a latch.
        ctrl      = CTRL_IDLE;
        state_d   = state_q;
        illegal_d = 1'b0;
        bus_err_d = 1'b0;
        cause_d   = cause_q;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;  ctrl.instr_read = 1'b1;
                ctrl.pc_en = mem_ready;  ctrl.fetch_en = mem_ready;
                ctrl.alu_in1_src = A1_PC;  ctrl.alu_in2_src = A2_FOUR;
                ctrl.result_src = RS_ALURES;  ctrl.alu_op = OP_ADD;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctrl.rf_en = 1'b1;
                case (opCode)
                    OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
                    OPC_OP_IMM:          state_d = S_EXEC_I;
                    OPC_OP:              state_d = (MULDIV_EN && funct7 == F7_MULDIV) ? S_MD_START : S_EXEC_R;
                    OPC_AUIPC:           state_d = S_EXEC_AUIPC;
                    OPC_LUI:             state_d = S_EXEC_LUI;
                    OPC_JALR:            state_d = S_PC_JALR;
                    OPC_JAL:             state_d = S_PC_JAL;
                    OPC_BRANCH:          state_d = S_COMPARE;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                        cause_d   = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctrl.aluout_en = 1'b1;  ctrl.alu_op = OP_ADD;
                state_d = opCode[5] ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                ctrl.mem_req = 1'b1;  ctrl.data_en = mem_ready;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WRITE: begin
                ctrl.mem_req = 1'b1;  ctrl.mem_we = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_MEM_WB: begin
                ctrl.reg_we = 1'b1;  ctrl.result_src = RS_DATA;
                state_d = S_FETCH;
            end
            S_EXEC_R: begin
                ctrl.aluout_en = 1'b1;  ctrl.alu_in2_src = A2_RS2;
                state_d = S_REG_WRITE;
            end
            S_EXEC_I: begin
                ctrl.aluout_en = 1'b1;
                state_d = S_REG_WRITE;
            end
            S_EXEC_AUIPC: begin
                ctrl.aluout_en = 1'b1;  ctrl.alu_in1_src = A1_OLDPC;  ctrl.alu_op = OP_ADD;
                state_d = S_REG_WRITE;
            end
            S_EXEC_LUI: begin
                ctrl.aluout_en = 1'b1;  ctrl.alu_in1_src = A1_ZERO;  ctrl.alu_op = OP_ADD;
                state_d = S_REG_WRITE;
            end
            S_PC_JALR: begin
                ctrl.pc_en = 1'b1;  ctrl.result_src = RS_ALURES;  ctrl.alu_op = OP_ADD;
                state_d = S_RD_CALC;
            end
            S_PC_JAL, S_PC_BRANCH: begin
                ctrl.pc_en = 1'b1;  ctrl.alu_in1_src = A1_OLDPC;
                ctrl.result_src = RS_ALURES;  ctrl.alu_op = OP_ADD;
                state_d = (state_q == S_PC_JAL) ? S_RD_CALC : S_FETCH;
            end
            S_RD_CALC: begin
                ctrl.aluout_en = 1'b1;  ctrl.alu_in1_src = A1_OLDPC;
                ctrl.alu_in2_src = A2_FOUR;  ctrl.alu_op = OP_ADD;
                state_d = S_REG_WRITE;
            end
            S_COMPARE: begin
                ctrl.alu_in2_src = A2_RS2;  ctrl.alu_op = OP_BRANCH;
                state_d = branch ? S_PC_BRANCH : S_FETCH;
            end
            S_REG_WRITE: begin
                ctrl.reg_we = 1'b1;
                state_d = S_FETCH;
            end
            S_MD_START: begin
                ctrl.md_start = 1'b1;
                state_d = S_MD_WAIT;
            end
            S_MD_WAIT: begin
                if (md_done) state_d = S_MD_WB;
            end
            S_MD_WB: begin
                ctrl.reg_we = 1'b1;  ctrl.result_src = RS_MD;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                if (!TRAP_HALT) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // The watchdog only fires while mem_ready is low, so a late ready still completes.
        if (wd_trip) begin
            state_d   = S_TRAP;
            bus_err_d = 1'b1;
            cause_d   = CAUSE_BUS;
        end

        if (!en) begin
            state_d   = state_q;
            illegal_d = 1'b0;
            bus_err_d = 1'b0;
            cause_d   = cause_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            cause_q   <= cause_d;
        end
    end

    // Enables fire only on advancing cycles; bus request and selects stay stable across en=0.
    assign adv           = en && !rst;
    assign mem_req       = ctrl.mem_req && !rst;
    assign instr_read    = ctrl.instr_read;
    assign mem_we        = ctrl.mem_we;
    assign pc_en         = ctrl.pc_en && adv;
    assign fetch_en      = ctrl.fetch_en && adv;
    assign rf_en         = ctrl.rf_en && adv;
    assign aluout_en     = ctrl.aluout_en && adv;
    assign data_en       = ctrl.data_en && adv;
    assign reg_we        = ctrl.reg_we && adv;
    assign md_start      = ctrl.md_start && adv;
    assign alu_in1_src   = ctrl.alu_in1_src;
    assign alu_in2_src   = ctrl.alu_in2_src;
    assign result_src    = ctrl.result_src;
    assign alu_op        = ctrl.alu_op;
    assign illegal_instr = illegal_q;
    assign bus_error     = bus_err_q;
    assign trap_cause    = cause_q;
    assign halted        = TRAP_HALT && (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_control_hs.sv
// Drives three parameter variants of the control FSM with shared stimulus and
// compares every output each cycle against a phase-level reference model.
module tb_multicycle_control_hs;

    localparam int NCFG = 3;
    localparam int P_TO [NCFG] = '{16, 4, 0};
    localparam bit P_MD [NCFG] = '{1'b0, 1'b1, 1'b1};
    localparam bit P_TH [NCFG] = '{1'b1, 1'b1, 1'b0};

    // Bit positions in the packed output word.
    localparam int B_REQ = 22, B_IR = 21, B_WE = 20, B_PC = 19, B_FE = 18, B_RF = 17;
    localparam int B_AO = 16, B_DE = 15, B_RW = 14, B_MS = 13, B_ILL = 4, B_BUS = 3, B_HALT = 0;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011;
    localparam logic [6:0] BAD = 7'b1111111, F7M = 7'b0000001;
    localparam logic [6:0] OPS [9] = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0010111,
                                       7'b0110111, 7'b1100111, 7'b1101111, 7'b1100011};

    typedef enum int {
        M_FETCH, M_DECODE, M_MEM_ADDR, M_MEM_READ, M_MEM_WRITE, M_MEM_WB, M_EXEC_R, M_EXEC_I,
        M_AUIPC, M_LUI, M_JALR, M_JAL, M_PC_BR, M_RD_CALC, M_COMPARE, M_REG_WRITE,
        M_MD_START, M_MD_WAIT, M_MD_WB, M_TRAP
    } ph_e;

    logic       clk = 1'b0;
    logic       rst, en, branch, mem_ready, md_done;
    logic [6:0] opCode, funct7;
    logic [22:0] obs [NCFG];
    logic [22:0] hist [NCFG][32];

    ph_e        m_ph    [NCFG];
    int         m_wait  [NCFG];
    logic [1:0] m_cause [NCFG];
    bit         m_ill   [NCFG];
    bit         m_bus   [NCFG];

    int n_vec = 0;
    int n_err = 0;
    int k_idx = 0;
    int t_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        logic req, ir, we, pc, fe, rf, ao, de, rw, ms, ill, berr, hlt;
        logic [1:0] a1, a2, rs, op, cause;
        multicycle_control_hs #(.TIMEOUT(P_TO[g]), .MULDIV_EN(P_MD[g]), .TRAP_HALT(P_TH[g])) u_dut (
            .clk(clk), .rst(rst), .en(en), .branch(branch), .opCode(opCode), .funct7(funct7),
            .mem_ready(mem_ready), .md_done(md_done), .mem_req(req), .instr_read(ir), .mem_we(we),
            .pc_en(pc), .fetch_en(fe), .rf_en(rf), .aluout_en(ao), .data_en(de), .reg_we(rw),
            .md_start(ms), .alu_in1_src(a1), .alu_in2_src(a2), .result_src(rs), .alu_op(op),
            .illegal_instr(ill), .bus_error(berr), .trap_cause(cause), .halted(hlt)
        );
        assign obs[g] = {req, ir, we, pc, fe, rf, ao, de, rw, ms, a1, a2, rs, op, ill, berr, cause, hlt};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ph_e after_decode(int i, logic [6:0] op, logic [6:0] f7);
        case (op)
            7'b0000011, 7'b0100011: return M_MEM_ADDR;
            7'b0010011: return M_EXEC_I;
            7'b0110011: return (P_MD[i] && f7 == 7'b0000001) ? M_MD_START : M_EXEC_R;
            7'b0010111: return M_AUIPC;
            7'b0110111: return M_LUI;
            7'b1100111: return M_JALR;
            7'b1101111: return M_JAL;
            7'b1100011: return M_COMPARE;
            default:    return M_TRAP;
        endcase
    endfunction

    // Output table of each phase, then the en/rst gating of enables and request.
    function automatic logic [22:0] expect_out(int i, bit e, bit r, bit rdy);
        logic req, ir, we, pc, fe, rf, ao, de, rw, ms;
        logic [1:0] a1, a2, rs, op;
        {req, ir, we, pc, fe, rf, ao, de, rw, ms} = '0;
        {a1, a2, rs, op} = '0;
        case (m_ph[i])
            M_FETCH:     begin req = 1; ir = 1; pc = rdy; fe = rdy; a1 = 3; a2 = 2; rs = 1; op = 2; end
            M_DECODE:    rf = 1;
            M_MEM_ADDR:  begin ao = 1; op = 2; end
            M_MEM_READ:  begin req = 1; de = rdy; end
            M_MEM_WRITE: begin req = 1; we = 1; end
            M_MEM_WB:    begin rw = 1; rs = 2; end
            M_EXEC_R:    begin ao = 1; a2 = 1; end
            M_EXEC_I:    ao = 1;
            M_AUIPC:     begin ao = 1; a1 = 2; op = 2; end
            M_LUI:       begin ao = 1; a1 = 1; op = 2; end
            M_JALR:      begin pc = 1; rs = 1; op = 2; end
            M_JAL, M_PC_BR: begin pc = 1; a1 = 2; rs = 1; op = 2; end
            M_RD_CALC:   begin ao = 1; a1 = 2; a2 = 2; op = 2; end
            M_COMPARE:   begin a2 = 1; op = 1; end
            M_REG_WRITE: rw = 1;
            M_MD_START:  ms = 1;
            M_MD_WB:     begin rw = 1; rs = 3; end
            default:     ;
        endcase
        if (!e || r) {pc, fe, rf, ao, de, rw, ms} = '0;
        if (r) req = 0;
        return {req, ir, we, pc, fe, rf, ao, de, rw, ms, a1, a2, rs, op,
                m_ill[i], m_bus[i], m_cause[i], (m_ph[i] == M_TRAP) && P_TH[i]};
    endfunction

    task automatic model_step(int i, bit e, bit r, logic [6:0] op, logic [6:0] f7, bit rdy, bit done, bit br);
        bit  waiting, expired;
        ph_e nxt;
        if (r) begin
            m_ph[i] = M_FETCH; m_wait[i] = 0; m_cause[i] = 2'b00; m_ill[i] = 0; m_bus[i] = 0;
            return;
        end
        m_ill[i] = 0;
        m_bus[i] = 0;
        if (!e) return;
        waiting = m_ph[i] inside {M_FETCH, M_MEM_READ, M_MEM_WRITE};
        expired = waiting && !rdy && P_TO[i] > 0 && m_wait[i] == P_TO[i] - 1;
        nxt = m_ph[i];
        case (m_ph[i])
            M_FETCH:     if (rdy) nxt = M_DECODE;
            M_DECODE: begin
                nxt = after_decode(i, op, f7);
                if (nxt == M_TRAP) begin m_ill[i] = 1; m_cause[i] = 2'b01; end
            end
            M_MEM_ADDR:  nxt = op[5] ? M_MEM_WRITE : M_MEM_READ;
            M_MEM_READ:  if (rdy) nxt = M_MEM_WB;
            M_MEM_WRITE: if (rdy) nxt = M_FETCH;
            M_EXEC_R, M_EXEC_I, M_AUIPC, M_LUI, M_RD_CALC: nxt = M_REG_WRITE;
            M_JALR, M_JAL: nxt = M_RD_CALC;
            M_COMPARE:   nxt = br ? M_PC_BR : M_FETCH;
            M_MD_START:  nxt = M_MD_WAIT;
            M_MD_WAIT:   if (done) nxt = M_MD_WB;
            M_TRAP:      nxt = P_TH[i] ? M_TRAP : M_FETCH;
            default:     nxt = M_FETCH;
        endcase
        if (expired) begin nxt = M_TRAP; m_bus[i] = 1; m_cause[i] = 2'b10; end
        m_wait[i] = (waiting && !rdy && !expired) ? m_wait[i] + 1 : 0;
        m_ph[i] = nxt;
    endtask

    // One clock: apply inputs, compare all variants at negedge, advance models at posedge.
    task automatic cyc(input bit e, input bit r, input logic [6:0] op, input logic [6:0] f7,
                       input bit rdy, input bit done, input bit br);
        en = e; rst = r; opCode = op; funct7 = f7; mem_ready = rdy; md_done = done; branch = br;
        @(negedge clk);
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("cfg%0d t%0d", i, t_cnt), 32'(obs[i]), 32'(expect_out(i, e, r, rdy)));
            if (k_idx < 32) hist[i][k_idx] = obs[i];
        end
        @(posedge clk);
        for (int i = 0; i < NCFG; i++) model_step(i, e, r, op, f7, rdy, done, br);
        #1;
        k_idx++;
        t_cnt++;
    endtask

    task automatic start_scenario();
        k_idx = 0;
        cyc(1, 1, 7'd0, 7'd0, 1, 0, 0);
    endtask

    function automatic logic [31:0] seq(int i, int b, int from, int n);
        logic [31:0] v = '0;
        for (int j = 0; j < n; j++) v[j] = hist[i][from + j][b];
        return v;
    endfunction

    initial begin
        rst = 1; en = 0; branch = 0; mem_ready = 0; md_done = 0; opCode = '0; funct7 = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NCFG; i++) model_step(i, 0, 1, 7'd0, 7'd0, 0, 0, 0);

        // R-type with funct7=0000001: plain EXEC_R when mul/div is disabled.
        start_scenario();
        for (int k = 1; k <= 5; k++) cyc(1, 0, RTYPE, F7M, 1, 0, 0);
        check("reset outputs", 32'(hist[0][0]),
              32'({1'b0, 1'b1, 1'b0, 7'b0, 2'b11, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0}));
        check("rtype pc_en seq", seq(0, B_PC, 1, 5), 32'b10001);
        check("rtype reg_we seq", seq(0, B_RW, 1, 5), 32'b01000);

        // Load with three stalled read cycles.
        start_scenario();
        for (int k = 1; k <= 8; k++) cyc(1, 0, LOAD, 7'd0, !(k >= 4 && k <= 6), 0, 0);
        check("load mem_req seq", seq(0, B_REQ, 4, 4), 32'hF);
        check("load data_en seq", seq(0, B_DE, 4, 4), 32'b1000);
        check("load wb rs/reg_we", 32'({hist[0][8][B_RW], hist[0][8][8:7]}), 32'b110);

        // Fetch never acknowledged: TIMEOUT=4 variant traps.
        start_scenario();
        for (int k = 1; k <= 7; k++) cyc(1, 0, RTYPE, 7'd0, 0, 0, 0);
        check("timeout bus_error seq", seq(1, B_BUS, 1, 7), 32'b0010000);
        check("timeout cause", 32'(hist[1][7][2:1]), 32'd2);
        check("timeout halted", 32'(hist[1][7][B_HALT]), 32'd1);
        check("no timeout at 16", seq(0, B_IR, 1, 7), 32'h7F);

        // Illegal opcode.
        start_scenario();
        for (int k = 1; k <= 5; k++) cyc(1, 0, BAD, 7'd0, 1, 0, 0);
        check("illegal pulse seq", seq(0, B_ILL, 1, 4), 32'b0100);
        check("illegal halted", 32'(hist[0][5][B_HALT]), 32'd1);
        check("trap return fetch", 32'({hist[2][4][B_REQ], hist[2][4][B_IR], hist[2][4][2:1]}), 32'b1101);

        // Mul/div with md_done five cycles after md_start.
        start_scenario();
        for (int k = 1; k <= 10; k++) cyc(1, 0, RTYPE, F7M, 1, k == 8, 0);
        check("md_start seq", seq(1, B_MS, 1, 10), 32'b0000000100);
        check("md_wb rs/reg_we", 32'({hist[1][9][B_RW], hist[1][9][8:7]}), 32'b111);

        // Store frozen by en=0, then reset in the middle of a mul/div wait.
        start_scenario();
        for (int k = 1; k <= 7; k++) cyc(k < 4 || k > 6, 0, STORE, 7'd0, 1, 0, 0);
        for (int k = 8; k <= 12; k++) cyc(1, 0, RTYPE, F7M, 1, 0, 0);
        cyc(1, 1, RTYPE, F7M, 1, 1, 0);
        cyc(1, 0, RTYPE, F7M, 0, 0, 0);
        check("en0 mem_req held", seq(0, B_REQ, 4, 4), 32'hF);
        check("en0 mem_we held", seq(0, B_WE, 4, 4), 32'hF);
        check("store done fetch", 32'(hist[0][8][B_IR]), 32'd1);
        check("rst enables off", 32'({hist[1][13][B_REQ], hist[1][13][19:13]}), 32'd0);
        check("rst to fetch", 32'({hist[1][14][B_REQ], hist[1][14][B_IR]}), 32'b11);

        // Randomised traffic.
        for (int n = 0; n < 1500; n++) begin
            int         idx;
            logic [6:0] op, f7;
            idx = $urandom_range(0, 10);
            op  = (idx >= 9) ? 7'($urandom) : OPS[idx];
            f7  = ($urandom_range(0, 1) != 0) ? F7M : 7'($urandom);
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 99) < 2, op, f7,
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 1) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
